io_scan_scheduler: RTL and testbench

Sequences the two board I/O engines, the sensor shift-register scanner and the LED strip driver, so that only one operation is outstanding at any time. Debounces raw sensor scans into a stable 32-bit board snapshot. Provides a req/ack freeze handshake so the CPU-side memory map reads a consistent snapshot. Sits between the sensor manager, the light controller and the memory manager, and runs on the 100 MHz system clock.

---
 rtl/io_sched_pkg.sv | 20 ++
 rtl/io_scan_scheduler_sensor_debounce.sv | 59 +++++
 rtl/io_scan_scheduler.sv | 135 +++++++++++++
 tb/tb_io_scan_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_sched_pkg.sv
// Shared constants and state encoding for the board I/O scan scheduler.
package io_sched_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned DEF_SCAN_PERIOD    = 100000;
  localparam int unsigned DEF_REFRESH_PERIOD = 1666667;
  localparam int unsigned DEF_STABLE_SCANS   = 3;
  localparam int unsigned DEF_TIMEOUT        = 2000000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_SCAN_WAIT  = 3'd1,
    ST_EVAL       = 3'd2,
    ST_LIGHT_WAIT = 3'd3,
    ST_FREEZE     = 3'd4
  } sched_state_e;

endpackage

// File: rtl/io_scan_scheduler_sensor_debounce.sv
// Debounces raw sensor scans: a value must repeat STABLE_SCANS times in a row
// before it replaces the published snapshot.
module sensor_debounce
  import io_sched_pkg::*;
#(
  parameter int unsigned STABLE_SCANS = DEF_STABLE_SCANS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              freeze,
  input  logic              flush,
  input  logic              snap_clear,
  output logic [DATA_W-1:0] snapshot,
  output logic              changed
);

  localparam int unsigned CNT_W = $clog2(STABLE_SCANS + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_SCANS);

  logic [DATA_W-1:0] candidate;
  logic [CNT_W-1:0]  stable_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              publish;

  // Run length of the current candidate including this scan, saturating.
  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (data == candidate) begin
      cnt_nxt = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + CNT_W'(1);
    end
    publish = scan_valid && (cnt_nxt == STABLE_MAX) && (data != snapshot) && !freeze;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      candidate  <= '0;
      stable_cnt <= '0;
      snapshot   <= '0;
      changed    <= 1'b0;
    end else begin
      if (flush) begin
        stable_cnt <= '0;
      end else if (scan_valid) begin
        candidate  <= data;
        stable_cnt <= cnt_nxt;
      end
      // A publish in the same cycle as a clear keeps the flag set.
      if (publish) begin
        snapshot <= data;
        changed  <= 1'b1;
      end else if (snap_clear) begin
        changed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_scan_scheduler.sv
// Serialises sensor scans and LED frames, debounces scans into a board
// snapshot and offers a req/ack freeze for consistent CPU reads.
module io_scan_scheduler
  import io_sched_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD    = DEF_SCAN_PERIOD,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int unsigned STABLE_SCANS   = DEF_STABLE_SCANS,
  parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  output logic               scan_start,
  input  logic               scan_done,
  input  logic [DATA_W-1:0]  scan_data,
  output logic               light_start,
  input  logic               light_done,
  input  logic               board_dirty,
  input  logic               snap_req,
  output logic               snap_ack,
  output logic [DATA_W-1:0]  sensor_snapshot,
  output logic               snap_changed,
  input  logic               snap_clear,
  output logic               timeout_err,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int unsigned SCAN_W = $clog2(SCAN_PERIOD + 1);
  localparam int unsigned REF_W  = $clog2(REFRESH_PERIOD + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  sched_state_e      state;
  logic [SCAN_W-1:0] scan_tmr;
  logic [REF_W-1:0]  ref_tmr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              dirty_pending;
  logic [DATA_W-1:0] raw_reg;
  logic              scan_due;
  logic              ref_due;
  logic              wait_expired;
  logic              scan_flush;

  // Timers hold at PERIOD-1 so a due event stays pending while an op runs.
  assign scan_due     = (scan_tmr == SCAN_W'(SCAN_PERIOD - 1));
  assign ref_due      = (ref_tmr == REF_W'(REFRESH_PERIOD - 1));
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign scan_flush   = (state == ST_SCAN_WAIT) && !scan_done && wait_expired;
  assign state_dbg    = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      scan_start    <= 1'b0;
      light_start   <= 1'b0;
      snap_ack      <= 1'b0;
      timeout_err   <= 1'b0;
      scan_tmr      <= '0;
      ref_tmr       <= '0;
      wait_cnt      <= '0;
      dirty_pending <= 1'b1;
      raw_reg       <= '0;
    end else begin
      scan_start  <= 1'b0;
      light_start <= 1'b0;
      if (!scan_due) scan_tmr <= scan_tmr + SCAN_W'(1);
      if (!ref_due) ref_tmr <= ref_tmr + REF_W'(1);
      if (board_dirty) dirty_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (snap_req && !snap_ack) begin
            state <= ST_FREEZE;
          end else if (dirty_pending || ref_due) begin
            light_start   <= 1'b1;
            ref_tmr       <= '0;
            dirty_pending <= board_dirty;
            wait_cnt      <= '0;
            state         <= ST_LIGHT_WAIT;
          end else if (scan_due) begin
            scan_start <= 1'b1;
            scan_tmr   <= '0;
            wait_cnt   <= '0;
            state      <= ST_SCAN_WAIT;
          end
        end
        ST_SCAN_WAIT: begin
          if (scan_done) begin
            raw_reg <= scan_data;
            state   <= ST_EVAL;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_EVAL: state <= ST_IDLE;
        ST_LIGHT_WAIT: begin
          if (light_done) begin
            state <= ST_IDLE;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_FREEZE: begin
          if (snap_req) begin
            snap_ack <= 1'b1;
          end else begin
            snap_ack <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sensor_debounce #(
    .STABLE_SCANS(STABLE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .scan_valid (state == ST_EVAL),
    .data       (raw_reg),
    .freeze     (snap_ack),
    .flush      (scan_flush),
    .snap_clear (snap_clear),
    .snapshot   (sensor_snapshot),
    .changed    (snap_changed)
  );

endmodule

// File: tb/tb_io_scan_scheduler.sv
// Scoreboard bench for io_scan_scheduler: an engine model answers start pulses,
// a debounce model predicts each evaluation, and a monitor checks them.
module tb_io_scan_scheduler;
  import io_sched_pkg::*;

  localparam int unsigned SP = 200;
  localparam int unsigned RP = 1000;
  localparam int unsigned SS = 3;
  localparam int unsigned TO = 300;
  localparam int W_LSTART = 0, W_LDONE = 1, W_SSTART = 2, W_ACK = 3, W_ANY = 4, W_TOUT = 5, W_SWAIT = 6;

  typedef struct packed {
    logic [31:0] snap;
    logic        chg;
  } exp_t;

  logic        clock, reset;
  logic        scan_start, scan_done, light_start, light_done;
  logic [31:0] scan_data, sensor_snapshot;
  logic        board_dirty, snap_req, snap_ack, snap_changed, snap_clear, timeout_err;
  logic [2:0]  state_dbg;

  int n_cmp = 0, n_fail = 0, cyc = 0, eval_cnt = 0, first_light = -1, first_scan = -1;
  bit withhold = 0, stray_en = 0;
  logic [31:0] m_snap = '0;
  bit m_changed = 0;
  logic [31:0] hist[$];
  logic [31:0] dq[$];
  exp_t exp_q[$];

  io_scan_scheduler #(
    .SCAN_PERIOD(SP), .REFRESH_PERIOD(RP), .STABLE_SCANS(SS), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .scan_start(scan_start), .scan_done(scan_done),
    .scan_data(scan_data), .light_start(light_start), .light_done(light_done),
    .board_dirty(board_dirty), .snap_req(snap_req), .snap_ack(snap_ack),
    .sensor_snapshot(sensor_snapshot), .snap_changed(snap_changed),
    .snap_clear(snap_clear), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    if (reset) cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cond(input int sel, input int budget, input string nm);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      case (sel)
        W_LSTART: hit = light_start;
        W_LDONE:  hit = light_done;
        W_SSTART: hit = scan_start;
        W_ACK:    hit = snap_ack;
        W_ANY:    hit = scan_start | light_start;
        W_TOUT:   hit = timeout_err;
        default:  hit = (state_dbg == ST_SCAN_WAIT);
      endcase
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_evals(input int n, input int budget, input string nm);
    int target = eval_cnt + n;
    for (int i = 0; i < budget && eval_cnt < target; i++) @(negedge clock);
    if (eval_cnt < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: saw %0d of %0d evaluations", nm, eval_cnt - target + n, n);
    end
  endtask

  // Reference: publish when the last SS scans since the last flush agree and differ from the snapshot.
  task automatic model_scan(input logic [31:0] v, input int mode);
    bit pub;
    if (mode == 1) m_changed = 0;
    hist.push_back(v);
    if (hist.size() > SS) void'(hist.pop_front());
    pub = (hist.size() == SS) && (v != m_snap);
    foreach (hist[i]) if (hist[i] != v) pub = 0;
    if (pub) begin
      m_snap    = v;
      m_changed = 1;
    end else if (mode == 2) begin
      m_changed = 0;
    end
    exp_q.push_back('{snap: m_snap, chg: m_changed});
  endtask

  // Engine model: answers light and scan starts; may withhold scan_done once.
  initial begin
    logic [31:0] pool [3];
    logic [31:0] v, last_v;
    int d, mode, s_cyc;
    bit to_seen;
    pool[0] = 32'h1234_5678; pool[1] = 32'h0000_00AA; pool[2] = 32'h8000_0001;
    last_v = pool[0];
    scan_done = 0; scan_data = '0; light_done = 0; snap_clear = 0;
    forever begin
      @(negedge clock);
      if (reset && light_start) begin
        repeat (10) @(posedge clock);
        #1 scan_done = stray_en; scan_data = 32'hDEAD_BEEF;
        @(posedge clock);
        #1 scan_done = 0;
        repeat (9) @(posedge clock);
        #1 light_done = 1;
        @(posedge clock);
        #1 light_done = 0;
      end else if (reset && scan_start) begin
        s_cyc = cyc;
        if (withhold) begin
          to_seen = 0;
          for (int i = 0; i < int'(TO) + 50 && !to_seen; i++) begin
            @(negedge clock);
            to_seen = timeout_err;
          end
          chk("timeout_seen", 32'(to_seen), 32'd1);
          chk("timeout_cycles", 32'(cyc - s_cyc), 32'(TO));
          chk("timeout_state_idle", 32'(state_dbg), 32'(ST_IDLE));
          hist.delete();
          withhold = 0;
        end else begin
          d    = $urandom_range(1, 8);
          mode = $urandom_range(0, 2);
          repeat (d) @(posedge clock);
          #1;
          if (mode == 1) begin
            snap_clear = 1;
            @(posedge clock);
            #1 snap_clear = 0;
          end
          if (dq.size() > 0) v = dq.pop_front();
          else begin
            v = ($urandom_range(0, 9) < 6) ? last_v : pool[$urandom_range(0, 2)];
            last_v = v;
          end
          scan_done = 1;
          scan_data = v;
          model_scan(v, mode);
          @(posedge clock);
          #1 scan_done = 0;
          if (mode == 2) begin
            snap_clear = 1;
            @(posedge clock);
            #1 snap_clear = 0;
          end
        end
      end
    end
  end

  // Monitor: after every EVAL cycle compare against the predicted result.
  initial begin
    bit post_eval = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) post_eval = 0;
      else begin
        if (post_eval) begin
          eval_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_eval: got an evaluation, expected none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("snapshot", sensor_snapshot, e.snap);
            chk("snap_changed", 32'(snap_changed), 32'(e.chg));
            chk("eval_to_idle", 32'(state_dbg), 32'(ST_IDLE));
          end
        end
        post_eval = (state_dbg == ST_EVAL);
        if (light_start && first_light < 0) first_light = cyc;
        if (scan_start && first_scan < 0) first_scan = cyc;
      end
    end
  end

  initial begin
    int t0, lat, viol;
    reset = 0; snap_req = 0; board_dirty = 0;
    repeat (3) @(negedge clock);
    chk("rst_scan_start", 32'(scan_start), 32'd0);
    chk("rst_light_start", 32'(light_start), 32'd0);
    chk("rst_snap_ack", 32'(snap_ack), 32'd0);
    chk("rst_snapshot", sensor_snapshot, 32'd0);
    chk("rst_snap_changed", 32'(snap_changed), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) dq.push_back(32'h0000_0F0F);
    for (int i = 0; i < 3; i++) dq.push_back(32'h0000_0F0E);
    dq.push_back(32'h0000_0F0F); dq.push_back(32'h0000_0F0E);
    for (int i = 0; i < 3; i++) dq.push_back(32'h0000_0F0F);
    @(posedge clock);
    #1 reset = 1;

    wait_evals(11, 5000, "directed_scans");
    chk("first_light_cycle", 32'(first_light), 32'd1);
    chk("first_scan_cycle", 32'(first_scan), 32'(SP));
    chk("directed_snapshot", sensor_snapshot, 32'h0000_0F0F);

    // board_dirty during a frame forces another frame right after light_done.
    stray_en = 1;
    wait_cond(W_LSTART, RP + 400, "dirty_frame_start");
    @(posedge clock);
    #1 board_dirty = 1;
    @(posedge clock);
    #1 board_dirty = 0;
    wait_cond(W_LDONE, 40, "dirty_frame_done");
    t0 = cyc;
    wait_cond(W_ANY, 10, "dirty_next_start");
    chk("dirty_light_first", 32'(light_start), 32'd1);
    chk("dirty_light_delay", 32'(cyc - t0), 32'd2);

    // Freeze requested mid-scan.
    for (int i = 0; i < 4; i++) dq.push_back(32'hFFFF_0000);
    wait_cond(W_SSTART, SP + RP, "freeze_scan_start");
    @(posedge clock);
    #1 snap_req = 1;
    t0 = cyc;
    wait_cond(W_ACK, TO + 10, "freeze_ack");
    lat = cyc - t0;
    chk("ack_latency_bound", 32'(lat <= int'(TO) + 2), 32'd1);
    chk("freeze_state", 32'(state_dbg), 32'(ST_FREEZE));
    viol = 0;
    for (int i = 0; i < 3 * int'(SP); i++) begin
      @(negedge clock);
      if (scan_start || light_start || !snap_ack || sensor_snapshot != m_snap) viol++;
      if (i == 10) begin
        @(posedge clock);
        #1 board_dirty = 1;
        @(posedge clock);
        #1 board_dirty = 0;
      end
    end
    chk("freeze_quiet_cycles_bad", 32'(viol), 32'd0);
    @(posedge clock);
    #1 snap_req = 0;
    @(posedge clock);
    @(negedge clock);
    chk("ack_drop", 32'(snap_ack), 32'd0);
    chk("unfreeze_state", 32'(state_dbg), 32'(ST_IDLE));
    wait_cond(W_ANY, 5, "unfreeze_start");
    chk("unfreeze_light_first", 32'(light_start), 32'd1);
    wait_evals(4, 3000, "post_freeze_scans");
    chk("post_freeze_snapshot", sensor_snapshot, 32'hFFFF_0000);

    // Withheld scan_done: timeout, then normal scanning resumes.
    chk("no_timeout_yet", 32'(timeout_err), 32'd0);
    withhold = 1;
    wait_cond(W_TOUT, 2 * int'(SP) + int'(RP) + int'(TO) + 100, "timeout_flag");
    wait_evals(4, 3000, "post_timeout_scans");

    wait_evals(30, 15000, "random_scans");
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of a scan.
    wait_cond(W_SWAIT, SP + RP, "reset_scan_wait");
    #2 reset = 0;
    #1;
    chk("midop_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("midop_rst_scan_start", 32'(scan_start), 32'd0);
    chk("midop_rst_snapshot", sensor_snapshot, 32'd0);
    chk("midop_rst_timeout", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge clock);
    chk("midop_rst_no_start", 32'(scan_start | light_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
